i2s_rx: RTL and testbench

- Standard-I2S receiver, the downstream partner of the I2S transmitter on the uio pins. Takes sck/ws/sd from off-chip and runs entirely in the system clock domain.
- Oversamples the three inputs, deserializes left and right words MSB-first, and presents them as registered samples with one-cycle valid strobes.
- Provides sticky framing-error and frame-count status sized for the register map's status bus.
- Used for PRBS loopback checking and audio capture.

---
 rtl/i2s_rx.sv | 160 ++++++++++++++++
 tb/tb_i2s_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx
//  Description : Standard-I2S receiver. Oversamples sck/ws/sd in the system
//                clock domain, deserializes left/right words MSB-first and
//                reports sticky framing errors and a completed-frame count.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx #(
    parameter int AUDIO_DW = 8,
    parameter int FCNT_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sck_i,
    input  logic                ws_i,
    input  logic                sd_i,
    input  logic                clr_err_i,
    output logic [AUDIO_DW-1:0] l_data_o,
    output logic [AUDIO_DW-1:0] r_data_o,
    output logic                l_valid_o,
    output logic                r_valid_o,
    output logic                frame_err_o,
    output logic [FCNT_W-1:0]   frame_cnt_o
);

    // Bit counter must hold 0 .. AUDIO_DW+1 (saturation point)
    localparam int c_CNT_W = $clog2(AUDIO_DW + 2);
    localparam logic [c_CNT_W-1:0] c_DW    = c_CNT_W'(AUDIO_DW);
    localparam logic [c_CNT_W-1:0] c_DW_M1 = c_CNT_W'(AUDIO_DW - 1);
    localparam logic [c_CNT_W-1:0] c_SAT   = c_CNT_W'(AUDIO_DW + 1);

    typedef enum logic [0:0] {
        S_HUNT = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sck_s1, r_sck_s2, r_sck_s3;
    logic                  r_ws_s1, r_ws_s2;
    logic                  r_sd_s1, r_sd_s2;
    logic                  r_ws_prev;
    logic [AUDIO_DW-1:0]   r_shift;
    logic [c_CNT_W-1:0]    r_n;

    logic                  w_rise;
    logic                  w_ws_chg;
    logic                  w_n_lt;
    logic                  w_len_err;
    logic [c_CNT_W-1:0]    w_align;
    logic [AUDIO_DW-1:0]   w_full;
    logic [AUDIO_DW-1:0]   w_word;

    // Two-flop synchronizers for all inputs, extra sck stage for edge detect
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_s3 <= 1'b0;
            r_ws_s1  <= 1'b0;
            r_ws_s2  <= 1'b0;
            r_sd_s1  <= 1'b0;
            r_sd_s2  <= 1'b0;
        end else begin
            r_sck_s1 <= sck_i;
            r_sck_s2 <= r_sck_s1;
            r_sck_s3 <= r_sck_s2;
            r_ws_s1  <= ws_i;
            r_ws_s2  <= r_ws_s1;
            r_sd_s1  <= sd_i;
            r_sd_s2  <= r_sd_s1;
        end
    end

    assign w_rise    = r_sck_s2 & ~r_sck_s3;
    assign w_ws_chg  = (r_ws_s2 != r_ws_prev);
    assign w_n_lt    = (r_n < c_DW);
    assign w_len_err = (r_n != c_DW_M1);

    // Word assembly: the boundary bit is appended only while the word still
    // has room; the result is then left-shifted so short words are MSB-aligned.
    always_comb begin
        w_full  = r_shift;
        w_align = '0;
        if (w_n_lt) begin
            w_full  = {r_shift[AUDIO_DW-2:0], r_sd_s2};
            w_align = c_DW_M1 - r_n;
        end
        w_word = w_full << w_align;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave HUNT on the first ws transition seen at an sck rise
    always_comb begin
        w_state_nxt = r_state;
        if (w_rise && (r_state == S_HUNT) && w_ws_chg) begin
            w_state_nxt = S_RECV;
        end
    end

    // Deserializer, output registers and status (error set wins over clear)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ws_prev   <= 1'b0;
            r_shift     <= '0;
            r_n         <= '0;
            l_data_o    <= '0;
            r_data_o    <= '0;
            l_valid_o   <= 1'b0;
            r_valid_o   <= 1'b0;
            frame_err_o <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            l_valid_o <= 1'b0;
            r_valid_o <= 1'b0;
            if (clr_err_i) begin
                frame_err_o <= 1'b0;
            end
            if (w_rise) begin
                r_ws_prev <= r_ws_s2;
                if (r_state == S_HUNT) begin
                    r_shift <= '0;
                    r_n     <= '0;
                end else if (w_ws_chg) begin
                    if (r_ws_prev) begin
                        r_data_o    <= w_word;
                        r_valid_o   <= 1'b1;
                        frame_cnt_o <= frame_cnt_o + FCNT_W'(1);
                    end else begin
                        l_data_o  <= w_word;
                        l_valid_o <= 1'b1;
                    end
                    if (w_len_err) begin
                        frame_err_o <= 1'b1;
                    end
                    r_shift <= '0;
                    r_n     <= '0;
                end else begin
                    if (w_n_lt) begin
                        r_shift <= {r_shift[AUDIO_DW-2:0], r_sd_s2};
                    end
                    if (r_n != c_SAT) begin
                        r_n <= r_n + c_CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_rx
//  Description : Directed self-checking bench for i2s_rx (AUDIO_DW=8,
//                FCNT_W=8, clk = 8x sck).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_rx;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       sck    = 1'b0;
    logic       ws     = 1'b0;
    logic       sd     = 1'b0;
    logic       clr    = 1'b0;
    logic [7:0] l_data;
    logic [7:0] r_data;
    logic       l_valid;
    logic       r_valid;
    logic       err;
    logic [7:0] cnt;

    int tests = 0;
    int fails = 0;
    int l_pulses = 0;
    int r_pulses = 0;
    int overlap = 0;
    int wide = 0;
    logic prev_l = 1'b0;
    logic prev_r = 1'b0;
    int lp_snap;
    int rp_snap;

    i2s_rx #(.AUDIO_DW(8), .FCNT_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sck_i       (sck),
        .ws_i        (ws),
        .sd_i        (sd),
        .clr_err_i   (clr),
        .l_data_o    (l_data),
        .r_data_o    (r_data),
        .l_valid_o   (l_valid),
        .r_valid_o   (r_valid),
        .frame_err_o (err),
        .frame_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling clock edge
    always @(negedge clk) begin
        if (l_valid) l_pulses <= l_pulses + 1;
        if (r_valid) r_pulses <= r_pulses + 1;
        if (l_valid && r_valid) overlap <= overlap + 1;
        if ((l_valid && prev_l) || (r_valid && prev_r)) wide <= wide + 1;
        prev_l <= l_valid;
        prev_r <= r_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sck period: ws/sd change with the falling edge, 4 clk low, 4 clk high
    task automatic sck_cycle(input logic w, input logic d);
        @(negedge clk);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Send bits[hi:lo] of a word for channel ch; bit 0 goes out with ws already toggled
    task automatic send_range(input logic ch, input logic [15:0] bits, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            sck_cycle((i == 0) ? ~ch : ch, bits[i]);
        end
    endtask

    task automatic send_word(input logic ch, input logic [15:0] bits, input int nb);
        send_range(ch, bits, nb - 1, 0);
    endtask

    // Final bit: returns just after sck has been raised (between clk edges)
    task automatic fall_last(input logic w, input logic d);
        @(negedge clk);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_l_data", 32'(l_data), 32'h0);
        check("rst_r_data", 32'(r_data), 32'h0);
        check("rst_l_valid", 32'(l_valid), 32'h0);
        check("rst_r_valid", 32'(r_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_cnt", 32'(cnt), 32'h0);
        rst_n = 1'b1;

        // Idle left bits, then a left word that only ends HUNT
        repeat (3) sck_cycle(1'b0, 1'b1);
        send_word(1'b0, 16'h00A5, 8);
        check("hunt_no_l", 32'(l_pulses), 32'd0);
        check("hunt_no_r", 32'(r_pulses), 32'd0);
        send_word(1'b1, 16'h003C, 8);
        check("first_r_data", 32'(r_data), 32'h3C);
        check("first_cnt", 32'(cnt), 32'd1);
        for (int f = 0; f < 3; f++) begin
            send_word(1'b0, 16'h00A5, 8);
            send_word(1'b1, 16'h003C, 8);
            check("frame_l_data", 32'(l_data), 32'hA5);
            check("frame_r_data", 32'(r_data), 32'h3C);
            check("frame_cnt", 32'(cnt), 32'(f + 2));
            check("frame_err", 32'(err), 32'h0);
        end
        check("l_pulse_count", 32'(l_pulses), 32'd3);
        check("r_pulse_count", 32'(r_pulses), 32'd4);

        // 10-bit left word 1011011011: truncated to 0xB6, error
        send_word(1'b0, 16'h02DB, 10);
        check("long_l_data", 32'(l_data), 32'hB6);
        check("long_err", 32'(err), 32'h1);
        send_word(1'b1, 16'h003C, 8);
        clr_pulse();
        check("clr_err", 32'(err), 32'h0);
        send_word(1'b0, 16'h02DB, 10);
        check("long_err_again", 32'(err), 32'h1);
        clr_pulse();
        send_word(1'b1, 16'h003C, 8);
        check("ok_word_no_err", 32'(err), 32'h0);

        // 6-bit right word 101101: MSB-aligned 0xB4, error
        send_word(1'b0, 16'h00A5, 8);
        send_word(1'b1, 16'h002D, 6);
        check("short_r_data", 32'(r_data), 32'hB4);
        check("short_err", 32'(err), 32'h1);
        clr_pulse();
        check("short_clr", 32'(err), 32'h0);
        check("cnt_before_rst", 32'(cnt), 32'd7);

        // Reset mid-left-word
        send_word(1'b0, 16'h00A5, 8);
        send_word(1'b1, 16'h003C, 8);
        check("pre_rst_r_data", 32'(r_data), 32'h3C);
        lp_snap = l_pulses;
        rp_snap = r_pulses;
        send_range(1'b0, 16'h00A5, 7, 5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_l_data", 32'(l_data), 32'h0);
        check("mid_rst_r_data", 32'(r_data), 32'h0);
        check("mid_rst_cnt", 32'(cnt), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        send_range(1'b0, 16'h00A5, 4, 0);
        check("post_rst_no_l", 32'(l_pulses), 32'(lp_snap));
        check("post_rst_no_r", 32'(r_pulses), 32'(rp_snap));
        send_word(1'b1, 16'h003C, 8);
        check("post_rst_r_data", 32'(r_data), 32'h3C);
        check("post_rst_r_pulse", 32'(r_pulses), 32'(rp_snap + 1));
        check("post_rst_cnt", 32'(cnt), 32'd1);

        // Frame counter wrap and boundary latency
        for (int f = 0; f < 254; f++) begin
            send_word(1'b0, 16'h00A5, 8);
            send_word(1'b1, 16'h003C, 8);
        end
        check("cnt_255", 32'(cnt), 32'd255);
        send_word(1'b0, 16'h00A5, 8);
        send_range(1'b1, 16'h003C, 7, 1);
        fall_last(1'b0, 1'b0);
        @(posedge clk); #1;
        check("lat_edge1", 32'(r_valid), 32'h0);
        @(posedge clk); #1;
        check("lat_edge2", 32'(r_valid), 32'h0);
        @(posedge clk); #1;
        check("lat_edge3", 32'(r_valid), 32'h1);
        check("cnt_wrap", 32'(cnt), 32'd0);
        check("wrap_r_data", 32'(r_data), 32'h3C);
        @(posedge clk); #1;
        check("lat_edge4", 32'(r_valid), 32'h0);
        repeat (2) @(negedge clk);

        // Clear held across a length-error boundary: set wins
        clr = 1'b1;
        send_range(1'b0, 16'h02DB, 9, 1);
        fall_last(1'b1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("clr_pre_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        check("clr_set_same_err", 32'(err), 32'h1);
        check("clr_set_same_lv", 32'(l_valid), 32'h1);
        clr = 1'b0;
        @(posedge clk); #1;
        check("err_hold", 32'(err), 32'h1);
        repeat (2) @(negedge clk);

        check("no_overlap", 32'(overlap), 32'd0);
        check("single_cycle", 32'(wide), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
